// File: rtl/square_wave_generator_if.sv
// Tone bus between the period selector (master) and the square-wave generator (slave).
interface square_wave_generator_if #(
    parameter int AMP_W = 8
);
    logic [7:0]              halfPeriod;
    logic                    wave;
    logic signed [AMP_W-1:0] sample;
    logic                    note_active;
    logic                    edge_strobe;

    modport master (
        output halfPeriod,
        input  wave, sample, note_active, edge_strobe
    );

    modport slave (
        input  halfPeriod,
        output wave, sample, note_active, edge_strobe
    );
endinterface

// File: rtl/square_wave_generator.sv
// Square-wave tone generator: period changes and note release only take effect
// at half-cycle boundaries, so the output never glitches.
module square_wave_generator #(
    parameter int PRESCALE  = 64,
    parameter int AMP_W     = 8,
    parameter int AMPLITUDE = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    square_wave_generator_if.slave bus
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
    localparam logic signed [AMP_W-1:0] AMP_POS = AMP_W'(AMPLITUDE);
    localparam logic signed [AMP_W-1:0] AMP_NEG = -AMP_POS;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state, state_n;
    logic [7:0]              hp_q;
    logic [7:0]              period_l, period_n;
    logic [7:0]              cnt, cnt_n;
    logic [PW-1:0]           pre, pre_n;
    logic                    wave_q, wave_n;
    logic                    strobe_q, strobe_n;
    logic                    active_q, active_n;
    logic signed [AMP_W-1:0] sample_q, sample_n;
    logic                    tick;
    logic                    half_end;

    assign tick     = (pre == PRE_MAX);
    assign half_end = tick && (cnt == period_l - 8'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            hp_q     <= '0;
            period_l <= '0;
            cnt      <= '0;
            pre      <= '0;
            wave_q   <= 1'b0;
            strobe_q <= 1'b0;
            active_q <= 1'b0;
            sample_q <= '0;
        end else begin
            state    <= state_n;
            hp_q     <= bus.halfPeriod;
            period_l <= period_n;
            cnt      <= cnt_n;
            pre      <= pre_n;
            wave_q   <= wave_n;
            strobe_q <= strobe_n;
            active_q <= active_n;
            sample_q <= sample_n;
        end
    end

    // hp_q is only consulted at a half-cycle end, keeping each half-cycle phase-continuous.
    always_comb begin
        state_n  = state;
        period_n = period_l;
        cnt_n    = cnt;
        pre_n    = pre;
        wave_n   = wave_q;
        strobe_n = 1'b0;

        case (state)
            IDLE: begin
                pre_n  = '0;
                wave_n = 1'b0;
                if (hp_q != 8'd0) begin
                    state_n  = RUN;
                    wave_n   = 1'b1;
                    period_n = hp_q;
                    cnt_n    = 8'd0;
                    strobe_n = 1'b1;
                end
            end
            RUN: begin
                if (tick) begin
                    pre_n = '0;
                    if (half_end) begin
                        cnt_n    = 8'd0;
                        strobe_n = 1'b1;
                        if (hp_q == 8'd0) begin
                            state_n = IDLE;
                            wave_n  = 1'b0;
                        end else begin
                            wave_n   = ~wave_q;
                            period_n = hp_q;
                        end
                    end else begin
                        cnt_n = cnt + 8'd1;
                    end
                end else begin
                    pre_n = pre + PW'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        active_n = (state_n == RUN);
        if (!active_n)
            sample_n = '0;
        else if (wave_n)
            sample_n = AMP_POS;
        else
            sample_n = AMP_NEG;
    end

    assign bus.wave        = wave_q;
    assign bus.sample      = sample_q;
    assign bus.note_active = active_q;
    assign bus.edge_strobe = strobe_q;
endmodule

// File: tb/tb_square_wave_generator.sv
// Bench for square_wave_generator: two instances (PRESCALE 1 and 4) share one input
// and are compared every clock against a countdown model of the tone behaviour.
module tb_square_wave_generator;
    logic       clk;
    logic       rst;
    logic [7:0] hp_in;

    int compared;
    int mismatched;

    square_wave_generator_if #(.AMP_W(8)) bus0 ();
    square_wave_generator_if #(.AMP_W(8)) bus1 ();

    assign bus0.halfPeriod = hp_in;
    assign bus1.halfPeriod = hp_in;

    square_wave_generator #(.PRESCALE(1), .AMP_W(8), .AMPLITUDE(64)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    square_wave_generator #(.PRESCALE(4), .AMP_W(8), .AMPLITUDE(64)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [10:0] act0, act1;
    assign act0 = {bus0.wave, bus0.note_active, bus0.edge_strobe, bus0.sample};
    assign act1 = {bus1.wave, bus1.note_active, bus1.edge_strobe, bus1.sample};

    // Reference: each note is a run of half-cycles of hp*PRESCALE clocks, counted down.
    logic [7:0] m_hp;
    int         m_rem[2];
    logic       m_wave[2];
    logic       m_active[2];
    logic       m_strobe[2];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_hp <= 8'd0;
            for (int d = 0; d < 2; d++) begin
                m_rem[d]    <= 0;
                m_wave[d]   <= 1'b0;
                m_active[d] <= 1'b0;
                m_strobe[d] <= 1'b0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                int   rem;
                int   scale;
                logic w, a, s;
                scale = (d == 0) ? 1 : 4;
                rem = m_rem[d];
                w   = m_wave[d];
                a   = m_active[d];
                s   = 1'b0;
                if (!a) begin
                    if (m_hp != 8'd0) begin
                        a   = 1'b1;
                        w   = 1'b1;
                        rem = int'(m_hp) * scale;
                        s   = 1'b1;
                    end
                end else begin
                    rem = rem - 1;
                    if (rem == 0) begin
                        s = 1'b1;
                        if (m_hp == 8'd0) begin
                            a = 1'b0;
                            w = 1'b0;
                        end else begin
                            w   = ~w;
                            rem = int'(m_hp) * scale;
                        end
                    end
                end
                m_rem[d]    <= rem;
                m_wave[d]   <= w;
                m_active[d] <= a;
                m_strobe[d] <= s;
            end
            m_hp <= hp_in;
        end
    end

    function automatic logic [10:0] exp_vec(input int d);
        logic signed [7:0] s;
        if (!m_active[d])
            s = 8'sd0;
        else if (m_wave[d])
            s = 8'sd64;
        else
            s = -8'sd64;
        return {m_wave[d], m_active[d], m_strobe[d], s};
    endfunction

    task automatic test_reset();
        rst   = 1'b0;
        hp_in = 8'd5;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            compared++;
            if (act0 !== 11'd0) begin
                mismatched++;
                $display("FAIL reset dut0 cyc %0d: got %h want %h", i, act0, 11'd0);
            end
            compared++;
            if (act1 !== 11'd0) begin
                mismatched++;
                $display("FAIL reset dut1 cyc %0d: got %h want %h", i, act1, 11'd0);
            end
        end
        hp_in = 8'd0;
        rst   = 1'b1;
    endtask

    task automatic test_silence();
        hp_in = 8'd0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            compared++;
            if (act0 !== 11'd0) begin
                mismatched++;
                $display("FAIL silence dut0 cyc %0d: got %h want %h", i, act0, 11'd0);
            end
            compared++;
            if (act1 !== 11'd0) begin
                mismatched++;
                $display("FAIL silence dut1 cyc %0d: got %h want %h", i, act1, 11'd0);
            end
        end
    endtask

    task automatic test_start_steady();
        hp_in = 8'd92;
        @(negedge clk);
        compared++;
        if (bus0.wave !== 1'b0) begin
            mismatched++;
            $display("FAIL start_early wave: got %b want 0", bus0.wave);
        end
        @(negedge clk);
        compared++;
        if ({bus0.wave, bus0.note_active, bus0.edge_strobe} !== 3'b111) begin
            mismatched++;
            $display("FAIL start_rise: got %b want 111", {bus0.wave, bus0.note_active, bus0.edge_strobe});
        end
        for (int i = 0; i < 92 * 4; i++) begin
            @(negedge clk);
            compared++;
            if (act0 !== exp_vec(0)) begin
                mismatched++;
                $display("FAIL steady dut0 cyc %0d: got %h want %h", i, act0, exp_vec(0));
            end
            compared++;
            if (act1 !== exp_vec(1)) begin
                mismatched++;
                $display("FAIL steady dut1 cyc %0d: got %h want %h", i, act1, exp_vec(1));
            end
        end
    endtask

    task automatic test_period_change();
        int  i;
        bit  found;
        found = 1'b0;
        for (i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            compared++;
            if (act0 !== exp_vec(0)) begin
                mismatched++;
                $display("FAIL change_wait dut0 cyc %0d: got %h want %h", i, act0, exp_vec(0));
            end
            if (bus0.edge_strobe && bus0.wave) found = 1'b1;
        end
        compared++;
        if (!found) begin
            mismatched++;
            $display("FAIL change_timeout: got no high start want one within 400 clocks");
        end
        repeat (29) @(negedge clk);
        hp_in = 8'd50;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            compared++;
            if (act0 !== exp_vec(0)) begin
                mismatched++;
                $display("FAIL change dut0 cyc %0d: got %h want %h", k, act0, exp_vec(0));
            end
            compared++;
            if (act1 !== exp_vec(1)) begin
                mismatched++;
                $display("FAIL change dut1 cyc %0d: got %h want %h", k, act1, exp_vec(1));
            end
        end
    endtask

    task automatic test_release();
        int strobes;
        int lows;
        strobes = 0;
        lows    = 0;
        hp_in   = 8'd92;
        for (int i = 0; i < 1000 && lows == 0; i++) begin
            @(negedge clk);
            compared++;
            if (act0 !== exp_vec(0)) begin
                mismatched++;
                $display("FAIL release_wait dut0 cyc %0d: got %h want %h", i, act0, exp_vec(0));
            end
            if (bus0.edge_strobe) begin
                strobes++;
                if (strobes > 2 && !bus0.wave) lows = 1;
            end
        end
        compared++;
        if (lows == 0) begin
            mismatched++;
            $display("FAIL release_timeout: got no low start want one within 1000 clocks");
        end
        repeat (39) @(negedge clk);
        hp_in   = 8'd0;
        strobes = 0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            compared++;
            if (act0 !== exp_vec(0)) begin
                mismatched++;
                $display("FAIL release dut0 cyc %0d: got %h want %h", k, act0, exp_vec(0));
            end
            compared++;
            if (act1 !== exp_vec(1)) begin
                mismatched++;
                $display("FAIL release dut1 cyc %0d: got %h want %h", k, act1, exp_vec(1));
            end
            if (k >= 60 && bus0.edge_strobe) strobes++;
        end
        compared++;
        if (strobes != 0 || bus0.note_active !== 1'b0) begin
            mismatched++;
            $display("FAIL release_quiet: got %0d strobes active %b want 0 strobes active 0", strobes, bus0.note_active);
        end
    endtask

    task automatic test_async_reset();
        bit found;
        hp_in = 8'd92;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (bus0.edge_strobe && bus0.wave) found = 1'b1;
        end
        compared++;
        if (!found) begin
            mismatched++;
            $display("FAIL areset_timeout: got no high start want one within 400 clocks");
        end
        repeat (10) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        compared++;
        if ({act0, act1} !== 22'd0) begin
            mismatched++;
            $display("FAIL areset_drop: got %h %h want 0 0", act0, act1);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        compared++;
        if (bus0.wave !== 1'b0) begin
            mismatched++;
            $display("FAIL areset_early wave: got %b want 0", bus0.wave);
        end
        @(negedge clk);
        compared++;
        if ({bus0.wave, bus0.note_active} !== 2'b11) begin
            mismatched++;
            $display("FAIL areset_rise: got %b want 11", {bus0.wave, bus0.note_active});
        end
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            compared++;
            if (act0 !== exp_vec(0)) begin
                mismatched++;
                $display("FAIL areset dut0 cyc %0d: got %h want %h", k, act0, exp_vec(0));
            end
            compared++;
            if (act1 !== exp_vec(1)) begin
                mismatched++;
                $display("FAIL areset dut1 cyc %0d: got %h want %h", k, act1, exp_vec(1));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq[4];
        int         prev;
        seq  = '{8'd50, 8'd92, 8'd50, 8'd92};
        prev = 92;
        for (int s = 0; s < 4; s++) begin
            hp_in = seq[s];
            for (int k = 0; k < 2 * prev; k++) begin
                @(negedge clk);
                compared++;
                if (act0 !== exp_vec(0)) begin
                    mismatched++;
                    $display("FAIL b2b dut0 seg %0d cyc %0d: got %h want %h", s, k, act0, exp_vec(0));
                end
                compared++;
                if (bus0.note_active !== 1'b1) begin
                    mismatched++;
                    $display("FAIL b2b_active seg %0d cyc %0d: got %b want 1", s, k, bus0.note_active);
                end
            end
            prev = int'(seq[s]);
        end
    endtask

    task automatic test_prescale();
        int last;
        hp_in = 8'd0;
        repeat (400) @(negedge clk);
        compared++;
        if (bus1.note_active !== 1'b0) begin
            mismatched++;
            $display("FAIL prescale_idle: got %b want 0", bus1.note_active);
        end
        hp_in = 8'd3;
        last  = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            compared++;
            if (act1 !== exp_vec(1)) begin
                mismatched++;
                $display("FAIL prescale dut1 cyc %0d: got %h want %h", k, act1, exp_vec(1));
            end
            if (bus1.edge_strobe) begin
                if (last >= 0) begin
                    compared++;
                    if (k - last != 12) begin
                        mismatched++;
                        $display("FAIL prescale_half: got %0d clocks want 12", k - last);
                    end
                end
                last = k;
            end
        end
        hp_in = 8'd1;
        repeat (20) @(negedge clk);
        for (int k = 0; k < 12; k++) begin
            logic prev_wave;
            prev_wave = bus0.wave;
            @(negedge clk);
            compared++;
            if (bus0.wave !== ~prev_wave || bus0.edge_strobe !== 1'b1) begin
                mismatched++;
                $display("FAIL toggle1 cyc %0d: got wave %b strobe %b want wave %b strobe 1", k, bus0.wave, bus0.edge_strobe, ~prev_wave);
            end
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 14; s++) begin
            int len;
            hp_in = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
            len   = int'($urandom_range(1, 80));
            for (int k = 0; k < len; k++) begin
                @(negedge clk);
                compared++;
                if (act0 !== exp_vec(0)) begin
                    mismatched++;
                    $display("FAIL random dut0 seg %0d cyc %0d hp %0d: got %h want %h", s, k, hp_in, act0, exp_vec(0));
                end
                compared++;
                if (act1 !== exp_vec(1)) begin
                    mismatched++;
                    $display("FAIL random dut1 seg %0d cyc %0d hp %0d: got %h want %h", s, k, hp_in, act1, exp_vec(1));
                end
            end
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b0;
        hp_in      = 8'd0;
        test_reset();
        test_silence();
        test_start_steady();
        test_period_change();
        test_release();
        test_async_reset();
        test_back_to_back();
        test_prescale();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/square_wave_generator.md
# square_wave_generator

Converts the 8-bit `halfPeriod` word from the key-to-period selector into an audible square wave. The block sits directly downstream of the period selector and upstream of the audio output / DAC path. Period changes take effect only at half-cycle boundaries, so the output never glitches. `halfPeriod` = 0 (no key held) lets the current half-cycle finish, then silences the output.

## Interface

Parameters:

- `PRESCALE`, 64: clocks per count tick; must be ≥ 1.
- `AMP_W`, 8: width of the signed `sample` output.
- `AMPLITUDE`, 64: magnitude driven on `sample`; must be in 1 … 2^(AMP_W-1)-1.

Ports:

- `clk`, in, 1: system clock.
- `rst`, in, 1: reset, asynchronous, active-low.
- `halfPeriod`, in, 8: half-period in ticks from the period selector; 0 means silence.
- `wave`, out, 1: square-wave output.
- `sample`, out, AMP_W (signed): +AMPLITUDE when `wave`=1, −AMPLITUDE when `wave`=0, 0 when idle.
- `note_active`, out, 1: high while in RUN.
- `edge_strobe`, out, 1: one-clock pulse on every `wave` toggle, and on the start edge.

## Operation

- Input register: `hp_q` ← `halfPeriod` on every `clk` edge. All decisions use `hp_q`, never the raw input.
- Internal state:
  - `period_l` (8b): latched half-period.
  - `cnt` (8b): tick counter.
  - `pre`: prescale counter, width clog2(PRESCALE), min 1.
  - FSM with states IDLE and RUN.
- Tick definition: `tick` = (`pre` == PRESCALE-1). `pre` wraps to 0 on tick and increments otherwise. `pre` is forced to 0 in IDLE and on entry to RUN.
- IDLE:
  - `wave`=0, `sample`=0, `note_active`=0.
  - If `hp_q` ≠ 0: go to RUN. On that edge set `wave`=1, `period_l`=`hp_q`, `cnt`=0, `pre`=0, and pulse `edge_strobe`.
- RUN, on a tick with `cnt` == `period_l`-1 (half-cycle end):
  - `cnt`=0 and `edge_strobe` pulses.
  - If `hp_q` == 0: go to IDLE with `wave`=0.
  - Otherwise toggle `wave` and set `period_l`=`hp_q`.
- RUN, on a tick before the half-cycle end: `cnt`++.
- RUN, no tick: hold all state.
- Changes to `hp_q` mid half-cycle are ignored until the next half-cycle end, which keeps the output phase-continuous.
- Arithmetic:
  - Compare `cnt` against `period_l`-1 in 8 bits.
  - `period_l` is never 0 in RUN, because it is only loaded from a non-zero `hp_q`.
  - `sample` is the sign-extended constant ±AMPLITUDE.
- Outputs are registered, not combinational from `hp_q`.

## Timing

- Reset (`rst`=0, async): `wave`=0, `sample`=0, `note_active`=0, `edge_strobe`=0, `hp_q`=0, `cnt`=0, `pre`=0, `period_l`=0, state IDLE.
- Reset asserted mid-note: outputs drop immediately. After release, the block restarts from IDLE.
- Start latency: `halfPeriod` changes to N≠0 before edge E0. `hp_q` is valid after E0. At E1, `wave` rises and `note_active`=1.
- Steady state: each half-cycle lasts exactly N·PRESCALE clocks, so the full period is 2·N·PRESCALE clocks.
- Period change: a new value is adopted at the first half-cycle end that occurs at least 1 clock after the input changes (1-cycle `hp_q` delay).
- Release: `halfPeriod` goes to 0 mid half-cycle. That half-cycle completes at full length. At its end edge, `wave`=0, `sample`=0 and `note_active`=0 together.
- Silence at start-up: `halfPeriod`=0 continuously keeps the block in IDLE with no strobes.
- N=1, PRESCALE=1: `wave` toggles every clock.

## Test plan

- PRESCALE=1, AMPLITUDE=64, `halfPeriod`=92 held: `wave` rises 2 clocks after the input changes, then alternates 92 high / 92 low. `sample` alternates +64 / −64. `edge_strobe` fires every 92 clocks.
- PRESCALE=1, 92 held; change to 50 at clock 30 of a high phase: the high phase still lasts 92 clocks, then the low phase is 50 and subsequent half-cycles are 50. No half-cycle has any other length.
- PRESCALE=1, 92 held; drop to 0 at clock 40 of a low phase: the low phase completes at 92 clocks. Then `note_active`=0 and `sample`=0, and no further strobes occur.
- PRESCALE=4, `halfPeriod`=3: each half-cycle is exactly 12 clocks. With `halfPeriod`=1 and PRESCALE=1, `wave` toggles every clock.
- Assert `rst` low asynchronously mid high-phase: `wave`, `sample` and `note_active` go to 0 before the next `clk` edge. After release with 92 still held, `wave` rises 2 clocks later and the first half-cycle is 92 clocks.
- Key switching back-to-back with no gap (92 → 50 → 92, each held for one full period): every half-cycle length equals the `hp_q` value sampled at its start boundary, and `note_active` never drops.
